// File: rtl/mem_access_pkg.sv
// Shared MEM-stage definitions: ALU op codes for memory instructions, FSM states,
// access-size classes and the ALU-op decode helpers used by mem_access and mem_align.
package mem_access_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 8;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;
  localparam logic [31:0]           INITIAL_PC    = 32'h0000_0000;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 8'h00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ORI = 8'h0D;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 8'h20;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LB  = 8'hE0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LH  = 8'hE1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LW  = 8'hE3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SB  = 8'hE8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SH  = 8'hE9;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SW  = 8'hEB;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_BUSY = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_st_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BYTE = 2'd1,
    SEL_HALF = 2'd2,
    SEL_WORD = 2'd3
  } mem_sel_e;

  function automatic mem_sel_e op_size(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_OP_LB, ALU_OP_SB: return SEL_BYTE;
      ALU_OP_LH, ALU_OP_SH: return SEL_HALF;
      ALU_OP_LW, ALU_OP_SW: return SEL_WORD;
      default:              return SEL_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, replicated store data and misalignment for the
// request side; lane extraction with sign extension for the load-return side.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [ALU_OP_W-1:0] i_aluop,
  input  logic [1:0]          i_addr_lo,
  input  logic [31:0]         i_reg2,
  input  logic [ALU_OP_W-1:0] i_ld_aluop,
  input  logic [1:0]          i_ld_addr_lo,
  input  logic [31:0]         i_rdata,
  output logic                o_is_mem,
  output logic                o_is_store,
  output logic [3:0]          o_sel,
  output logic [31:0]         o_wdata,
  output logic                o_misalign,
  output logic [31:0]         o_load_data
);

  mem_sel_e           w_size;
  mem_sel_e           w_ld_size;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  always_comb begin
    w_size     = op_size(i_aluop);
    o_is_mem   = (w_size != SEL_NONE);
    o_is_store = op_is_store(i_aluop);
    o_sel      = 4'b0000;
    o_wdata    = 32'h0;
    o_misalign = 1'b0;
    case (w_size)
      SEL_BYTE: begin
        o_sel   = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_reg2[7:0]}};
      end
      SEL_HALF: begin
        o_sel      = 4'b0011 << i_addr_lo;
        o_wdata    = {2{i_reg2[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      SEL_WORD: begin
        o_sel      = 4'b1111;
        o_wdata    = i_reg2;
        o_misalign = |i_addr_lo;
      end
      default: ;
    endcase
  end

  // Load side works on the latched op/offset so it lines up with the captured read data.
  always_comb begin
    w_ld_size = op_size(i_ld_aluop);
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half      = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load_data = i_rdata;
    case (w_ld_size)
      SEL_BYTE: o_load_data = 32'(w_byte);
      SEL_HALF: o_load_data = 32'(w_half);
      default:  o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes non-memory ops straight to MEM/WB and runs loads/stores on a
// variable-latency req/ack bus, stalling the pipeline until the access completes or times out.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           reg2_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_ack_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           pc_o,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [31:0]           data_addr_o,
  output logic [3:0]            data_sel_o,
  output logic [31:0]           data_wdata_o,
  output logic                  stallreq,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  mem_st_e               r_state, w_next;
  logic [TIMEOUT_W-1:0]  r_cnt;
  logic                  r_err;
  logic [REG_ADDR_W-1:0] r_wd;
  logic                  r_wreg;
  logic [31:0]           r_wdata, r_pc, r_addr, r_bus_wdata, r_rdata;
  logic [ALU_OP_W-1:0]   r_aluop;
  logic [1:0]            r_addr_lo;
  logic [3:0]            r_sel;
  logic                  r_we;

  logic                  w_is_mem, w_is_store, w_misalign;
  logic [3:0]            w_sel;
  logic [31:0]           w_bus_wdata, w_load_data;
  logic                  w_issue, w_timeout;

  mem_align u_align (
    .i_aluop      (aluop_i),
    .i_addr_lo    (mem_addr_i[1:0]),
    .i_reg2       (reg2_i),
    .i_ld_aluop   (r_aluop),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (r_rdata),
    .o_is_mem     (w_is_mem),
    .o_is_store   (w_is_store),
    .o_sel        (w_sel),
    .o_wdata      (w_bus_wdata),
    .o_misalign   (w_misalign),
    .o_load_data  (w_load_data)
  );

  assign w_issue   = (r_state == MEM_ST_IDLE) && !rst && w_is_mem && !w_misalign;
  // An ack in the final allowed cycle still completes the access normally.
  assign w_timeout = (r_state == MEM_ST_BUSY) && !data_ack_i &&
                     (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MEM_ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == MEM_ST_BUSY) ? r_cnt + 1'b1 : '0;
      if (r_state == MEM_ST_BUSY) r_err <= w_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_wd        <= wd_i;
      r_wreg      <= wreg_i;
      r_wdata     <= wdata_i;
      r_pc        <= pc_i;
      r_aluop     <= aluop_i;
      r_addr      <= {mem_addr_i[31:2], 2'b00};
      r_addr_lo   <= mem_addr_i[1:0];
      r_sel       <= w_sel;
      r_we        <= w_is_store;
      r_bus_wdata <= w_bus_wdata;
    end
    if ((r_state == MEM_ST_BUSY) && data_ack_i) r_rdata <= data_rdata_i;
  end

  always_comb begin
    w_next       = r_state;
    wd_o         = ZERO_REG_ADDR;
    wreg_o       = 1'b0;
    wdata_o      = 32'h0;
    pc_o         = INITIAL_PC;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_addr_o  = 32'h0;
    data_sel_o   = 4'b0000;
    data_wdata_o = 32'h0;
    stallreq     = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    case (r_state)
      MEM_ST_IDLE: begin
        if (!rst) begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
          pc_o    = pc_i;
          if (w_is_mem) begin
            wreg_o = 1'b0;
            if (w_misalign) begin
              misalign_o = 1'b1;
            end else begin
              stallreq = 1'b1;
              w_next   = MEM_ST_BUSY;
            end
          end
        end
      end
      MEM_ST_BUSY: begin
        data_req_o   = 1'b1;
        data_we_o    = r_we;
        data_addr_o  = r_addr;
        data_sel_o   = r_sel;
        data_wdata_o = r_bus_wdata;
        stallreq     = 1'b1;
        wd_o         = r_wd;
        pc_o         = r_pc;
        if (data_ack_i || w_timeout) w_next = MEM_ST_DONE;
      end
      MEM_ST_DONE: begin
        wd_o      = r_wd;
        pc_o      = r_pc;
        bus_err_o = r_err;
        if (r_err || r_we) begin
          wdata_o = r_wdata;
        end else begin
          wreg_o  = r_wreg;
          wdata_o = w_load_data;
        end
        w_next = MEM_ST_IDLE;
      end
      default: w_next = MEM_ST_IDLE;
    endcase
  end

endmodule
